// File: rtl/muldiv_pkg.sv
// Shared M-extension definitions: op codes, unit states and constants.
// Imported by the ALU decoder and the iterative mul/div unit.
package muldiv_pkg;

  localparam int MULDIV_ITERS = 32;

  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES         = 32'hFFFF_FFFF;

  typedef enum logic [4:0] {
    OP_MUL    = 5'b01010,
    OP_MULH   = 5'b01011,
    OP_MULHSU = 5'b01100,
    OP_MULHU  = 5'b01101,
    OP_DIV    = 5'b01110,
    OP_DIVU   = 5'b01111,
    OP_REM    = 5'b10000,
    OP_REMU   = 5'b10001
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic op_legal(
    input logic [4:0] op
  );
    return (op >= 5'b01010) && (op <= 5'b10001);
  endfunction

endpackage

// File: rtl/muldiv_shift_core.sv
// Unsigned 32-step shift-add multiplier / restoring divider.
// Operates on magnitudes; sign handling lives in the parent.
module muldiv_shift_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode_div,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  output logic [2*XLEN-1:0] acc,
  output logic [XLEN-1:0]   quo,
  output logic              last
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              run_q, run_d;
  logic              div_q, div_d;

  logic [XLEN:0]     shl;
  logic [XLEN+1:0]   diff;
  logic              ge;
  logic [XLEN:0]     sum;

  assign acc  = acc_q;
  assign quo  = quo_q;
  assign last = run_q && (cnt_q == 6'(MULDIV_ITERS - 1));

  // One iteration per cycle while running; start reloads all state.
  always_comb begin
    acc_d = acc_q;
    quo_d = quo_q;
    opb_d = opb_q;
    cnt_d = cnt_q;
    run_d = run_q;
    div_d = div_q;
    shl   = {acc_q[XLEN-1:0], quo_q[XLEN-1]};
    diff  = {1'b0, shl} - {2'b00, opb_q};
    ge    = ~diff[XLEN+1];
    sum   = {1'b0, acc_q[2*XLEN-1:XLEN]}
          + (quo_q[0] ? {1'b0, opb_q} : '0);
    if (start) begin
      acc_d = '0;
      quo_d = a_mag;
      opb_d = b_mag;
      cnt_d = '0;
      run_d = 1'b1;
      div_d = mode_div;
    end else if (run_q) begin
      cnt_d = cnt_q + 6'd1;
      run_d = ~last;
      if (div_q) begin
        acc_d = {{(XLEN-1){1'b0}}, ge ? diff[XLEN:0] : shl};
        quo_d = {quo_q[XLEN-2:0], ge};
      end else begin
        acc_d = {sum, acc_q[XLEN-1:1]};
        quo_d = {1'b0, quo_q[XLEN-1:1]};
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      quo_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      quo_q <= quo_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative RV32M execution unit: handshakes, FSM, signs, fast paths.
// Magnitude arithmetic is delegated to muldiv_shift_core.
module muldiv_iter_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            resp_illegal,
  output logic            busy
);

  muldiv_state_e   state_q, state_d;
  logic [4:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            ill_q, ill_d;

  logic            accept;
  logic            a_sgn, b_sgn, sa, sb;
  logic            is_div, is_rem, illegal;
  logic            div0, ovf, fast, neg_in;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;
  logic [XLEN-1:0] fix_res;
  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN-1:0] quo, qs, rs;
  logic            last;

  assign req_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign resp_valid   = (state_q == ST_DONE);
  assign resp_result  = res_q;
  assign resp_illegal = ill_q;
  assign accept       = req_valid && req_ready;

  // Request decode: signedness, magnitudes and fast-path detection.
  always_comb begin
    a_sgn   = req_op inside {OP_MUL, OP_MULH, OP_MULHSU,
                             OP_DIV, OP_REM};
    b_sgn   = req_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    is_div  = req_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    is_rem  = req_op inside {OP_REM, OP_REMU};
    illegal = ~op_legal(req_op);
    sa      = a_sgn & req_a[XLEN-1];
    sb      = b_sgn & req_b[XLEN-1];
    a_mag   = sa ? -req_a : req_a;
    b_mag   = sb ? -req_b : req_b;
    neg_in  = is_rem ? sa : (sa ^ sb);
    div0    = is_div && (req_b == '0);
    ovf     = (req_op inside {OP_DIV, OP_REM})
            && (req_a == DIV_OVF_DIVIDEND)
            && (req_b == ALL_ONES);
    fast    = illegal | div0 | ovf;
    fast_res = '0;
    unique case (1'b1)
      illegal: fast_res = '0;
      div0:    fast_res = is_rem ? req_a : ALL_ONES;
      ovf:     fast_res = is_rem ? '0 : DIV_OVF_DIVIDEND;
      default: fast_res = '0;
    endcase
  end

  muldiv_shift_core #(
    .XLEN (XLEN)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept && !fast),
    .mode_div (is_div),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .acc      (acc),
    .quo      (quo),
    .last     (last)
  );

  // Sign fix-up and result selection once iterations finish.
  always_comb begin
    prod = neg_q ? -acc : acc;
    qs   = neg_q ? -quo : quo;
    rs   = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    case (op_q)
      OP_MUL:  fix_res = prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV,
      OP_DIVU: fix_res = qs;
      default: fix_res = rs;
    endcase
  end

  // Control FSM and response registers.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    res_d   = res_q;
    ill_d   = ill_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = req_op;
          neg_d = neg_in;
          ill_d = 1'b0;
          if (fast) begin
            res_d   = fast_res;
            ill_d   = illegal;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: if (last) state_d = ST_FIX;
      ST_FIX: begin
        res_d   = fix_res;
        state_d = ST_DONE;
      end
      ST_DONE: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and response flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Bench for muldiv_iter_unit: directed cases, backpressure, reset
// abort, and random traffic against an arithmetic reference model.
module tb_muldiv_iter_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_illegal;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [32:0] exp_q[$];

  muldiv_iter_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_result  (resp_result),
    .resp_illegal (resp_illegal),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RISC-V M semantics from plain 64-bit arithmetic; {illegal, result}.
  function automatic logic [32:0] model(
    input logic [4:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint          sa, sb, q;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      5'd10: begin p = sa * sb; return {1'b0, p[31:0]}; end
      5'd11: begin p = sa * sb; return {1'b0, p[63:32]}; end
      5'd12: begin
        p = sa * longint'(ub);
        return {1'b0, p[63:32]};
      end
      5'd13: begin p = ua * ub; return {1'b0, p[63:32]}; end
      5'd14: begin
        if (b == 0) return {1'b0, 32'hFFFF_FFFF};
        if (sa == -64'sd2147483648 && sb == -64'sd1)
          return {1'b0, 32'h8000_0000};
        q = sa / sb;
        return {1'b0, q[31:0]};
      end
      5'd15: begin
        if (b == 0) return {1'b0, 32'hFFFF_FFFF};
        p = ua / ub;
        return {1'b0, p[31:0]};
      end
      5'd16: begin
        if (b == 0) return {1'b0, a};
        if (sa == -64'sd2147483648 && sb == -64'sd1)
          return {1'b0, 32'h0};
        q = sa % sb;
        return {1'b0, q[31:0]};
      end
      5'd17: begin
        if (b == 0) return {1'b0, a};
        p = ua % ub;
        return {1'b0, p[31:0]};
      end
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // Issue one op, wait for the response, then take it.
  task automatic run_op(
    input  logic [4:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res,
    output logic        ill,
    output int          lat
  );
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    req_op    = 5'(($urandom % 8) + 10);
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = resp_result;
    ill = resp_illegal;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  logic [4:0]  d_op [13];
  logic [31:0] d_a  [13];
  logic [31:0] d_b  [13];
  logic [31:0] d_r  [13];
  logic        d_i  [13];
  int          d_l  [13];

  initial begin
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          got;
    int          cyc;

    d_op = '{5'd10, 5'd11, 5'd13, 5'd12, 5'd14, 5'd16, 5'd15,
             5'd17, 5'd14, 5'd17, 5'd14, 5'd16, 5'd21};
    d_a  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9,
             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd1};
    d_b  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF,
             32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd2, 32'd0,
             32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
    d_r  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE,
             32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd3,
             32'd1, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
             32'd0};
    d_i  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    d_l  = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1, 1};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(resp_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_result", 64'(resp_result), 0);
    chk("rst_illegal", 64'(resp_illegal), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 1);

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], res, ill, lat);
      chk($sformatf("dir%0d_res", i), 64'(res), 64'(d_r[i]));
      chk($sformatf("dir%0d_ill", i), 64'(ill), 64'(d_i[i]));
      chk($sformatf("dir%0d_lat", i), 64'(lat), 64'(d_l[i]));
      chk($sformatf("dir%0d_rdy", i), 64'(req_ready), 1);
    end

    // Backpressure: DIVU 100 / 7 held for 5 cycles.
    @(negedge clk);
    req_op = 5'd15; req_a = 32'd100; req_b = 32'd7;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_lat", 64'(lat), 34);
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1;
      req_op = 5'd10; req_a = 32'd9; req_b = 32'd9;
      @(negedge clk);
      chk("bp_valid", 64'(resp_valid), 1);
      chk("bp_res", 64'(resp_result), 14);
      chk("bp_ill", 64'(resp_illegal), 0);
      chk("bp_rdy", 64'(req_ready), 0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp_after_rdy", 64'(req_ready), 1);
    chk("bp_after_busy", 64'(busy), 0);
    chk("bp_after_valid", 64'(resp_valid), 0);

    // Reset in the middle of a DIVU.
    @(negedge clk);
    req_op = 5'd15; req_a = 32'd1000; req_b = 32'd3;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy_pre", 64'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 64'(busy), 0);
    chk("mid_valid", 64'(resp_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rdy", 64'(req_ready), 1);
    chk("mid_res", 64'(resp_result), 0);
    chk("mid_ill", 64'(resp_illegal), 0);
    chk("mid_valid2", 64'(resp_valid), 0);
    run_op(5'd10, 32'd3, 32'd4, res, ill, lat);
    chk("mid_mul_res", 64'(res), 12);
    chk("mid_mul_lat", 64'(lat), 34);

    // Random traffic with random valid / ready.
    got = 0;
    fork
      begin : drv
        for (int i = 0; i < 200; i++) begin
          logic [4:0]  op;
          logic [31:0] a, b;
          bit          done;
          int          g;
          if ($urandom % 16 < 14) op = 5'(10 + ($urandom % 8));
          else op = 5'($urandom % 32);
          a = $urandom;
          b = $urandom;
          case ($urandom % 8)
            0: b = 32'd0;
            1: b = $urandom % 16;
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: ;
          endcase
          done = 1'b0;
          g = 0;
          while (!done && g < 5000) begin
            @(negedge clk);
            req_valid = ($urandom % 3) != 0;
            req_op = op;
            req_a  = a;
            req_b  = b;
            if (req_valid && req_ready) begin
              exp_q.push_back(model(op, a, b));
              done = 1'b1;
            end
            g++;
            @(posedge clk);
          end
        end
        @(negedge clk);
        req_valid = 1'b0;
      end
      begin : mon
        logic [32:0] e;
        cyc = 0;
        while (got < 200 && cyc < 60000) begin
          @(negedge clk);
          resp_ready = ($urandom % 2) != 0;
          if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
              chk("rnd_extra", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk($sformatf("rnd%0d_res", got),
                  64'(resp_result), 64'(e[31:0]));
              chk($sformatf("rnd%0d_ill", got),
                  64'(resp_illegal), 64'(e[32]));
            end
            got++;
          end
          cyc++;
        end
        @(negedge clk);
        resp_ready = 1'b0;
      end
    join
    chk("rnd_count", 64'(got), 200);
    chk("rnd_left", 64'(exp_q.size()), 0);
    repeat (3) @(negedge clk);
    chk("rnd_idle", 64'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
